// File: rtl/oc8051_defines.sv
// Shared constants for the 8051 interrupt arbiter: SFR addresses, vectors,
// source indices and FSM state encodings.
package oc8051_defines;

    localparam logic [7:0] OC8051_SFR_IE = 8'hA8;
    localparam logic [7:0] OC8051_SFR_IP = 8'hB8;

    localparam logic [7:0] OC8051_VEC_IE0 = 8'h03;
    localparam logic [7:0] OC8051_VEC_TF0 = 8'h0B;
    localparam logic [7:0] OC8051_VEC_IE1 = 8'h13;
    localparam logic [7:0] OC8051_VEC_TF1 = 8'h1B;
    localparam logic [7:0] OC8051_VEC_SER = 8'h23;
    localparam logic [7:0] OC8051_VEC_TF2 = 8'h2B;

    localparam logic [2:0] OC8051_SRC_IE0 = 3'd0;
    localparam logic [2:0] OC8051_SRC_TF0 = 3'd1;
    localparam logic [2:0] OC8051_SRC_IE1 = 3'd2;
    localparam logic [2:0] OC8051_SRC_TF1 = 3'd3;
    localparam logic [2:0] OC8051_SRC_SER = 3'd4;
    localparam logic [2:0] OC8051_SRC_TF2 = 3'd5;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    function automatic logic [7:0] oc8051_int_vec(input logic [2:0] idx);
        case (idx)
            OC8051_SRC_IE0: return OC8051_VEC_IE0;
            OC8051_SRC_TF0: return OC8051_VEC_TF0;
            OC8051_SRC_IE1: return OC8051_VEC_IE1;
            OC8051_SRC_TF1: return OC8051_VEC_TF1;
            OC8051_SRC_SER: return OC8051_VEC_SER;
            default:        return OC8051_VEC_TF2;
        endcase
    endfunction

endpackage

// File: rtl/oc8051_int_prio.sv
// Fixed-priority selector over six requests; bit 0 has the highest priority.
module oc8051_int_prio (
    input  logic [5:0] req,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Walk downwards so the lowest set bit is the last assignment.
        for (int i = 5; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/oc8051_int_arb.sv
// 8051 interrupt arbiter: IE/IP masking, two-level nesting and the
// intr/ack/reti handshake with the instruction selector.
module oc8051_int_arb
    import oc8051_defines::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ie0,
    input  logic       tf0,
    input  logic       ie1,
    input  logic       tf1,
    input  logic       ser,
    input  logic       tf2,
    input  logic       it0,
    input  logic       it1,
    input  logic       ack,
    input  logic       reti,
    input  logic       wr,
    input  logic [7:0] wr_addr,
    input  logic [7:0] data_in,
    input  logic [7:0] rd_addr,
    output logic       intr,
    output logic [7:0] int_v,
    output logic [7:0] data_out,
    output logic       clr_ie0,
    output logic       clr_tf0,
    output logic       clr_ie1,
    output logic       clr_tf1,
    output logic [1:0] dbg_state,
    output logic [1:0] dbg_isr
);

    // Handshake: intr is a one-cycle request; ack is only honoured in WAIT,
    // and the DONE cycle gives the peripheral time to drop its flag.
    arb_state_t  state;
    logic [7:0]  ie_r;
    logic [5:0]  ip_r;
    logic        isr_hi, isr_lo;
    logic        isr_hi_n, isr_lo_n;
    logic [2:0]  lat_idx;
    logic        lat_hi;

    logic [5:0]  src, req;
    logic        hi_v, lo_v, sel_v, sel_hi;
    logic [2:0]  hi_idx, lo_idx, sel_idx;
    logic        take_ack;

    assign src = {tf2, ser, tf1, ie1, tf0, ie0};
    assign req = src & ie_r[5:0] & {6{ie_r[7]}};

    oc8051_int_prio u_prio_hi (.req(req & ip_r),  .valid(hi_v), .idx(hi_idx));
    oc8051_int_prio u_prio_lo (.req(req & ~ip_r), .valid(lo_v), .idx(lo_idx));

    always_comb begin
        sel_v   = 1'b0;
        sel_idx = hi_idx;
        sel_hi  = 1'b1;
        if (!isr_hi) begin
            if (hi_v) begin
                sel_v = 1'b1;
            end else if (!isr_lo && lo_v) begin
                sel_v   = 1'b1;
                sel_idx = lo_idx;
                sel_hi  = 1'b0;
            end
        end
    end

    // reti clears first so a same-cycle ack can re-set a level.
    assign take_ack = (state == ARB_WAIT) && ack;

    always_comb begin
        isr_hi_n = isr_hi;
        isr_lo_n = isr_lo;
        if (reti) begin
            if (isr_hi) isr_hi_n = 1'b0;
            else        isr_lo_n = 1'b0;
        end
        if (take_ack) begin
            if (lat_hi) isr_hi_n = 1'b1;
            else        isr_lo_n = 1'b1;
        end
    end

    always_comb begin
        case (rd_addr)
            OC8051_SFR_IE: data_out = ie_r;
            OC8051_SFR_IP: data_out = {2'b00, ip_r};
            default:       data_out = 8'h00;
        endcase
    end

    assign dbg_state = state;
    assign dbg_isr   = {isr_hi, isr_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            ie_r    <= 8'h00;
            ip_r    <= 6'h00;
            isr_hi  <= 1'b0;
            isr_lo  <= 1'b0;
            lat_idx <= 3'd0;
            lat_hi  <= 1'b0;
            intr    <= 1'b0;
            int_v   <= 8'h00;
            clr_ie0 <= 1'b0;
            clr_tf0 <= 1'b0;
            clr_ie1 <= 1'b0;
            clr_tf1 <= 1'b0;
        end else begin
            if (wr && wr_addr == OC8051_SFR_IE) ie_r <= data_in;
            if (wr && wr_addr == OC8051_SFR_IP) ip_r <= data_in[5:0];
            isr_hi  <= isr_hi_n;
            isr_lo  <= isr_lo_n;
            intr    <= 1'b0;
            clr_ie0 <= 1'b0;
            clr_tf0 <= 1'b0;
            clr_ie1 <= 1'b0;
            clr_tf1 <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (sel_v) begin
                        intr    <= 1'b1;
                        int_v   <= oc8051_int_vec(sel_idx);
                        lat_idx <= sel_idx;
                        lat_hi  <= sel_hi;
                        state   <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (ack) begin
                        clr_ie0 <= (lat_idx == OC8051_SRC_IE0) && it0;
                        clr_tf0 <= (lat_idx == OC8051_SRC_TF0);
                        clr_ie1 <= (lat_idx == OC8051_SRC_IE1) && it1;
                        clr_tf1 <= (lat_idx == OC8051_SRC_TF1);
                        state   <= ARB_DONE;
                    end
                end
                ARB_DONE: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end

endmodule
